// File: rtl/stream_fanout_pkg.sv
// stream_fanout_pkg: channel limit and full-width destination mask type shared by stream_fanout
package stream_fanout_pkg;
  localparam int FANOUT_MAX_CHANNELS = 16;
  typedef logic [FANOUT_MAX_CHANNELS-1:0] fanout_mask_t;
endpackage

// File: rtl/stream_fanout_channel.sv
// stream_fanout_channel: one pending flag; ports clk/rst, load value + load_en, consumer out_ready -> out_valid, drain (still pending next cycle)
module stream_fanout_channel
  import stream_fanout_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_en,
  input  logic out_ready,
  output logic out_valid,
  output logic drain
);
  logic r_pending;
  assign out_valid = r_pending;
  assign drain     = r_pending & ~out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_pending <= 1'b0;
    else     r_pending <= load_en ? load : drain;
endmodule

// File: rtl/stream_fanout.sv
// stream_fanout: registered 1->CHANNELS valid/ready broadcast; in_* producer side, out_* shared data + per-channel valid/ready, in_mask only with STREAM_FANOUT_MASK_EN
module stream_fanout
  import stream_fanout_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
`ifdef STREAM_FANOUT_MASK_EN
  input  logic [CHANNELS-1:0] in_mask,
`endif
  output logic [WIDTH-1:0]    out_data,
  output logic [CHANNELS-1:0] out_valid,
  input  logic [CHANNELS-1:0] out_ready
);
  localparam fanout_mask_t ALL_CH = '1;
  logic [CHANNELS-1:0] w_load;
  logic [CHANNELS-1:0] w_drain;
  logic                w_accept;
  logic [WIDTH-1:0]    r_data;
`ifdef STREAM_FANOUT_MASK_EN
  assign w_load = in_mask;
`else
  assign w_load = ALL_CH[CHANNELS-1:0];
`endif
  // Accept once every channel is idle or completing now, so reloads never create a bubble
  assign in_ready = ~rst & ~|w_drain;
  assign w_accept = in_valid & in_ready;
  assign out_data = r_data;
  always_ff @(posedge clk or posedge rst)
    if (rst)           r_data <= '0;
    else if (w_accept) r_data <= in_data;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    stream_fanout_channel u_ch (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load[c]),
      .load_en   (w_accept),
      .out_ready (out_ready[c]),
      .out_valid (out_valid[c]),
      .drain     (w_drain[c])
    );
  end
endmodule

// File: tb/tb_stream_fanout.sv
// tb_stream_fanout: directed and scoreboarded checks of stream_fanout at CHANNELS 2, 4 and 3
module tb_stream_fanout;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  d2_data = '0;  logic d2_valid = 1'b0; logic d2_ir; logic [7:0]  d2_od; logic [1:0] d2_ov; logic [1:0] d2_ready = '0;
  logic [7:0]  d4_data = '0;  logic d4_valid = 1'b0; logic d4_ir; logic [7:0]  d4_od; logic [3:0] d4_ov; logic [3:0] d4_ready = '0;
  logic [31:0] d3_data = '0;  logic d3_valid = 1'b0; logic d3_ir; logic [31:0] d3_od; logic [2:0] d3_ov; logic [2:0] d3_ready = '0;
`ifdef STREAM_FANOUT_MASK_EN
  logic [1:0] d2_mask = 2'b11;
  logic [3:0] d4_mask = 4'hF;
  logic [2:0] d3_mask = 3'b111;
`endif

  stream_fanout #(.WIDTH(8), .CHANNELS(2)) u2 (
    .clk(clk), .rst(rst), .in_data(d2_data), .in_valid(d2_valid), .in_ready(d2_ir),
`ifdef STREAM_FANOUT_MASK_EN
    .in_mask(d2_mask),
`endif
    .out_data(d2_od), .out_valid(d2_ov), .out_ready(d2_ready));

  stream_fanout #(.WIDTH(8), .CHANNELS(4)) u4 (
    .clk(clk), .rst(rst), .in_data(d4_data), .in_valid(d4_valid), .in_ready(d4_ir),
`ifdef STREAM_FANOUT_MASK_EN
    .in_mask(d4_mask),
`endif
    .out_data(d4_od), .out_valid(d4_ov), .out_ready(d4_ready));

  stream_fanout #(.WIDTH(32), .CHANNELS(3)) u3 (
    .clk(clk), .rst(rst), .in_data(d3_data), .in_valid(d3_valid), .in_ready(d3_ir),
`ifdef STREAM_FANOUT_MASK_EN
    .in_mask(d3_mask),
`endif
    .out_data(d3_od), .out_valid(d3_ov), .out_ready(d3_ready));

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q [3][$];
  logic acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard for u3: retire consumer handshakes against the queue, then enqueue an accepted beat
  task automatic sb_cycle(output logic accepted);
    accepted = d3_valid & d3_ir;
    for (int i = 0; i < 3; i++)
      if (d3_ov[i] & d3_ready[i]) begin
        if (q[i].size() != 0) check("rand_data", d3_od, q[i].pop_front());
        else check("rand_dup", q[i].size(), 1);
      end
    if (accepted)
      for (int i = 0; i < 3; i++) q[i].push_back(d3_data);
  endtask

  initial begin
    step();
    step();
    check("rst_ir", d2_ir, 0);
    check("rst_ov", d2_ov, 0);
    check("rst_od", d2_od, 0);
    check("rst_ov4", d4_ov, 0);
    rst = 1'b0;
    #1;
    check("rel_ir", d2_ir, 1);
    d2_valid = 1'b1; d2_data = 8'hA5; d2_ready = 2'b00;
    step();
    d2_data = 8'h5A; d2_ready = 2'b01;
    #1;
    check("skew_ov1", d2_ov, 2'b11);
    check("skew_od1", d2_od, 8'hA5);
    check("skew_ir1", d2_ir, 0);
    step();
    check("skew_ov2", d2_ov, 2'b10);
    check("skew_od2", d2_od, 8'hA5);
    check("skew_ir2", d2_ir, 0);
    step();
    check("skew_ov3", d2_ov, 2'b10);
    check("skew_ir3", d2_ir, 0);
    d2_ready = 2'b10;
    #1;
    check("skew_ir4", d2_ir, 1);
    step();
    check("skew_ov5", d2_ov, 2'b11);
    check("skew_od5", d2_od, 8'h5A);
    d2_valid = 1'b0; d2_ready = 2'b01;
    step();
    check("same_pre", d2_ov, 2'b10);
    d2_ready = 2'b10; d2_valid = 1'b1; d2_data = 8'h3C;
    #1;
    check("same_ir", d2_ir, 1);
    step();
    check("same_ov", d2_ov, 2'b11);
    check("same_od", d2_od, 8'h3C);
    d2_valid = 1'b0; d2_ready = 2'b11;
    #1;
    check("drain_ir", d2_ir, 1);
    step();
    check("drain_ov", d2_ov, 2'b00);
    check("drain_od", d2_od, 8'h3C);
    d2_valid = 1'b1; d2_data = 8'h99; d2_ready = 2'b00;
    step();
    d2_valid = 1'b0;
    check("mid_ov", d2_ov, 2'b11);
    rst = 1'b1;
    #1;
    check("mid_rst_ov", d2_ov, 0);
    check("mid_rst_od", d2_od, 0);
    check("mid_rst_ir", d2_ir, 0);
    step();
    rst = 1'b0;
    #1;
    check("mid_rel_ir", d2_ir, 1);
    step();
    check("mid_rel_ov", d2_ov, 0);
    d4_ready = 4'hF;
    for (int k = 1; k <= 16; k++) begin
      d4_valid = 1'b1; d4_data = 8'(k);
      #1;
      check("strm_ir", d4_ir, 1);
      step();
      check("strm_ov", d4_ov, 4'hF);
      check("strm_od", d4_od, k);
    end
    d4_valid = 1'b0;
    step();
    check("strm_end", d4_ov, 0);
`ifdef STREAM_FANOUT_MASK_EN
    d4_ready = 4'h0; d4_valid = 1'b1; d4_data = 8'h77; d4_mask = 4'b0101;
    step();
    check("mask_ov", d4_ov, 4'b0101);
    check("mask_od", d4_od, 8'h77);
    d4_ready = 4'hF; d4_data = 8'h88; d4_mask = 4'b0000;
    #1;
    check("mask0_ir", d4_ir, 1);
    step();
    d4_valid = 1'b0;
    check("mask0_ov", d4_ov, 0);
    check("mask0_od", d4_od, 8'h88);
`endif
    acc = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      if (acc || !d3_valid) begin
        d3_valid = ($urandom % 4) != 0;
        d3_data  = $urandom;
      end
      d3_ready = 3'($urandom);
      #1;
      sb_cycle(acc);
      step();
    end
    d3_valid = 1'b0; d3_ready = 3'b111;
    repeat (3) begin
      #1;
      sb_cycle(acc);
      step();
    end
    for (int i = 0; i < 3; i++) check("rand_left", q[i].size(), 0);
    check("rand_ov_end", d3_ov, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_fanout.md
# stream_fanout

Parametrised broadcast stage: one valid/ready input stream is copied to CHANNELS independent valid/ready output streams, each consumer accepting the beat in its own cycle. A registered generalisation of plain wire fan-out. Sits between a single producer and several consumers that stall independently. Provides one-cycle registered latency and full one-beat-per-cycle throughput when all consumers are ready.

## Interface
Parameters:
- WIDTH, 8, payload width in bits (>= 1)
- CHANNELS, 2, number of output streams (2..16)

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  WIDTH  payload
- in_valid  input  1  producer offers a beat
- in_ready  output  1  stage accepts the beat this cycle
- in_mask  input  CHANNELS  destination mask (present only with STREAM_FANOUT_MASK_EN)
- out_data  output  WIDTH  shared registered payload, same value on all channels
- out_valid  output  CHANNELS  per-channel beat pending
- out_ready  input  CHANNELS  per-channel consumer accepts

## Operation
- State: data register (WIDTH) plus pending vector (CHANNELS); out_valid = pending.
- Channel i completes when pending[i] & out_ready[i]; pending[i] clears at the edge.
- drain = pending & ~out_ready; in_ready = ~rst & (drain == 0). The stage accepts when every channel is idle or completing this cycle.
- On accept (in_valid & in_ready): data <= in_data; pending <= all-ones (or in_mask with the macro).
- No accept: pending <= drain; data holds.
- Accept and final completions in the same cycle: completions take effect and the new beat loads. There is no bubble.
- in_valid without in_ready: nothing changes. The producer must hold in_data and in_valid stable until accepted.
- Consumers see out_data stable while their out_valid is high.
- Channels are never re-presented a beat they already took, and beat order is preserved on every channel.

## Timing
- Reset (asynchronous assert, synchronous release at edge): pending = 0, out_valid = 0, out_data = 0, in_ready = 0 while rst is high, in_ready = 1 after release.
- Latency: beat accepted at edge N is on out_valid/out_data from edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle when all out_ready are high.
- A slow channel stalls all channels for new beats. Channels that already completed the current beat idle.
- in_ready depends combinationally on out_ready; there is no combinational path from in_valid or in_data to any output.
- Reset mid-beat: pending beats are discarded, with no partial delivery after release.

## Configuration
- STREAM_FANOUT_MASK_EN defined: the in_mask port exists and pending loads in_mask on accept.
  - Only masked channels see the beat.
  - in_mask == 0: the beat is accepted (in_ready as normal) and dropped. pending stays 0 and out_data still updates.
- Not defined: no in_mask port; every accepted beat goes to all channels.

## Structure
- Package stream_fanout_pkg holds:
  - constant FANOUT_MAX_CHANNELS = 16
  - typedef logic [FANOUT_MAX_CHANNELS-1:0] fanout_mask_t, sliced to CHANNELS in the block
- Sub-module stream_fanout_channel, instantiated CHANNELS times, holds one pending flag.
  - Inputs: load, load_en, out_ready. Outputs: out_valid, drain.
  - Its async-reset flop is the only per-channel state.
- The top holds the data register and the in_ready reduction.

## Test plan
- Reset: assert rst mid-beat with pending = 2'b11 -> out_valid = 0 and out_data = 0 immediately. in_ready = 0 during reset and 1 on the cycle after release.
- Streaming: CHANNELS = 4, out_ready = 4'hF, in_data = 0x01..0x10 back-to-back -> in_ready stays 1 and each channel receives 16 beats in order, each one cycle after acceptance.
- Skew: CHANNELS = 2, beat 0xA5; out_ready = 2'b01 for 3 cycles, then 2'b10 -> ch0 takes 0xA5 once and drops valid. in_ready = 0 until ch1 accepts, then the next beat loads in that same cycle.
- Same-cycle completion and reload: pending = 2'b10, out_ready[1] = 1, in_valid = 1 with 0x3C -> in_ready = 1 and out_valid = 2'b11 with out_data = 0x3C the following cycle.
- Mask (STREAM_FANOUT_MASK_EN): in_mask = 4'b0101 with 0x77 -> only ch0 and ch2 are valid. in_mask = 0 with 0x88 -> beat accepted, out_valid stays 0.
- Random stalls: random in_valid/out_ready over 10k cycles, WIDTH = 32, CHANNELS = 3 -> each channel's output sequence equals the input sequence. No duplicates and no losses.
